// File: rtl/branch_predictor_f.sv
// ---------------------------------------------------------------------------
// branch_predictor_f
//
// Direct-mapped branch target buffer with a 2-bit saturating counter per
// entry. The fetch stage looks up the current PC combinationally. The decode
// stage feeds back the resolved outcome, which updates the table and raises
// a same-cycle redirect when the earlier prediction was wrong.
//
// Optional feature (macro BP_STATS_EN):
//   When defined, two 32-bit statistics counters are added:
//     oLookupCount      - counts cycles with an update event
//     oMispredictCount  - counts cycles with oPCSrcD asserted
//   When undefined, those ports and counters do not exist.
//
// Parameters:
//   ENTRIES        table depth (power of two, 4..64)
//   XLEN           PC / target width
//
// Ports:
//   iClk           clock, rising edge
//   iRst           asynchronous active-low reset
//   iPCF           fetch PC being looked up
//   oPCSrcF        predict taken for iPCF
//   oBranchTarget  predicted target (entry target on hit, else iPCF+4)
//   iBranchD       decode instruction is a branch/jump
//   iTakenD        resolved outcome
//   iPCD           decode instruction PC
//   iTargetD       resolved taken target
//   iPredTakenD    prediction that travelled with this instruction
//   iPredTargetD   predicted target that travelled with this instruction
//   iStallD        decode stalled (no update, no redirect)
//   iFlushD        decode squashed (no update, no redirect)
//   oPCSrcD        mispredict, fetch must redirect
//   oTargetPC      corrected fetch PC
// ---------------------------------------------------------------------------
module branch_predictor_f #(
  parameter int ENTRIES = 16,
  parameter int XLEN    = 32
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic [XLEN-1:0] iPCF,
  output logic            oPCSrcF,
  output logic [XLEN-1:0] oBranchTarget,
  input  logic            iBranchD,
  input  logic            iTakenD,
  input  logic [XLEN-1:0] iPCD,
  input  logic [XLEN-1:0] iTargetD,
  input  logic            iPredTakenD,
  input  logic [XLEN-1:0] iPredTargetD,
  input  logic            iStallD,
  input  logic            iFlushD,
  output logic            oPCSrcD,
  output logic [XLEN-1:0] oTargetPC
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     oLookupCount,
  output logic [31:0]     oMispredictCount
`endif
);

  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - 2 - IW;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  // Table storage. Only valid bits and counters are reset; a cleared valid
  // bit makes the stale tag and target unobservable.
  logic            valid_q  [ENTRIES];
  logic [1:0]      ctr_q    [ENTRIES];
  logic [TW-1:0]   tag_q    [ENTRIES];
  logic [XLEN-1:0] target_q [ENTRIES];

  // Fetch-side lookup
  logic [IW-1:0] idxF;
  logic [TW-1:0] tagF;
  logic          hitF;

  // Decode-side update
  logic [IW-1:0] idxD;
  logic [TW-1:0] tagD;
  logic          hitD;
  logic          updEn;
  logic          allocEn;
  logic          ctrWe;
  logic          tgtWe;
  logic [1:0]    ctr_d;

  assign idxF = iPCF[IW+1:2];
  assign tagF = iPCF[XLEN-1:IW+2];
  assign idxD = iPCD[IW+1:2];
  assign tagD = iPCD[XLEN-1:IW+2];

  // Zero-latency lookup. It reads the registered table, so an update to the
  // same index in this cycle is only seen from the next cycle on.
  always_comb begin
    hitF          = valid_q[idxF] && (tag_q[idxF] == tagF);
    oPCSrcF       = hitF && ctr_q[idxF][1];
    oBranchTarget = hitF ? target_q[idxF] : (iPCF + PC_STEP);
  end

  // Resolution in decode. A redirect is needed when the direction was wrong,
  // or when a taken branch was predicted taken to the wrong target.
  always_comb begin
    updEn     = iBranchD && !iStallD && !iFlushD;
    oPCSrcD   = updEn && ((iTakenD != iPredTakenD) ||
                          (iTakenD && (iPredTargetD != iTargetD)));
    oTargetPC = iTakenD ? iTargetD : (iPCD + PC_STEP);
  end

  // Next-state selection for the single entry touched by an update. A hit
  // moves the counter one step toward the outcome; a taken miss allocates
  // the entry weakly-taken; a not-taken miss leaves the table untouched.
  always_comb begin
    hitD    = valid_q[idxD] && (tag_q[idxD] == tagD);
    allocEn = 1'b0;
    ctrWe   = 1'b0;
    tgtWe   = 1'b0;
    ctr_d   = ctr_q[idxD];
    if (updEn) begin
      if (hitD) begin
        ctrWe = 1'b1;
        tgtWe = iTakenD;
        if (iTakenD) begin
          ctr_d = (ctr_q[idxD] == 2'b11) ? 2'b11 : (ctr_q[idxD] + 2'b01);
        end else begin
          ctr_d = (ctr_q[idxD] == 2'b00) ? 2'b00 : (ctr_q[idxD] - 2'b01);
        end
      end else if (iTakenD) begin
        allocEn = 1'b1;
        ctrWe   = 1'b1;
        tgtWe   = 1'b1;
        ctr_d   = 2'b10;
      end
    end
  end

  // Valid bits and counters: cleared asynchronously, so an update coinciding
  // with reset is lost.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ctrWe) begin
      ctr_q[idxD] <= ctr_d;
      if (allocEn) begin
        valid_q[idxD] <= 1'b1;
      end
    end
  end

  // Tags and targets carry no reset. Writes are still blocked while reset
  // is held so that an update overlapping reset leaves no trace at all.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      if (tgtWe) begin
        target_q[idxD] <= iTargetD;
      end
      if (allocEn) begin
        tag_q[idxD] <= tagD;
      end
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookupCount_q;
  logic [31:0] mispredictCount_q;

  // Free-running statistics; they wrap naturally at 2^32.
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      lookupCount_q     <= 32'd0;
      mispredictCount_q <= 32'd0;
    end else begin
      if (updEn) begin
        lookupCount_q <= lookupCount_q + 32'd1;
      end
      if (oPCSrcD) begin
        mispredictCount_q <= mispredictCount_q + 32'd1;
      end
    end
  end

  assign oLookupCount     = lookupCount_q;
  assign oMispredictCount = mispredictCount_q;
`endif

endmodule

// File: tb/tb_branch_predictor_f.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor_f
//
// Directed-vector bench for branch_predictor_f (ENTRIES=16, XLEN=32).
// Each vector is driven just after a rising edge together with its
// hand-computed expected outputs, which go into a scoreboard queue. A
// monitor on the falling edge pops and compares them against the DUT.
// ---------------------------------------------------------------------------
module tb_branch_predictor_f;

  logic        iClk;
  logic        iRst;
  logic [31:0] iPCF;
  logic        oPCSrcF;
  logic [31:0] oBranchTarget;
  logic        iBranchD;
  logic        iTakenD;
  logic [31:0] iPCD;
  logic [31:0] iTargetD;
  logic        iPredTakenD;
  logic [31:0] iPredTargetD;
  logic        iStallD;
  logic        iFlushD;
  logic        oPCSrcD;
  logic [31:0] oTargetPC;
`ifdef BP_STATS_EN
  logic [31:0] oLookupCount;
  logic [31:0] oMispredictCount;
`endif

  typedef struct {
    string       name;
    logic        expPcsrcF;
    logic [31:0] expBtF;
    logic        expPcsrcD;
    logic [31:0] expTgtPC;
    logic [31:0] expLookups;
    logic [31:0] expMispredicts;
  } expT;

  expT sbQ[$];

  int vectorCount   = 0;
  int miscompares   = 0;
  int lookupTally   = 0;
  int mispredTally  = 0;

  branch_predictor_f #(.ENTRIES(16), .XLEN(32)) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iPCF          (iPCF),
    .oPCSrcF       (oPCSrcF),
    .oBranchTarget (oBranchTarget),
    .iBranchD      (iBranchD),
    .iTakenD       (iTakenD),
    .iPCD          (iPCD),
    .iTargetD      (iTargetD),
    .iPredTakenD   (iPredTakenD),
    .iPredTargetD  (iPredTargetD),
    .iStallD       (iStallD),
    .iFlushD       (iFlushD),
    .oPCSrcD       (oPCSrcD),
`ifdef BP_STATS_EN
    .oTargetPC       (oTargetPC),
    .oLookupCount    (oLookupCount),
    .oMispredictCount(oMispredictCount)
`else
    .oTargetPC     (oTargetPC)
`endif
  );

  // 10 ns clock
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time (actual running, required finished)");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison; bumps the counters the summary line reports
  task automatic checkOutput(input string name, input string field,
                             input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, exp);
    end
  endtask

  // Monitor: the DUT outputs are combinational, so each vector's response
  // is present once its inputs settle; it is compared on the falling edge.
  always @(negedge iClk) begin
    while (sbQ.size() > 0) begin
      expT e;
      e = sbQ.pop_front();
      checkOutput(e.name, "oPCSrcF",       {31'd0, oPCSrcF}, {31'd0, e.expPcsrcF});
      checkOutput(e.name, "oBranchTarget", oBranchTarget,    e.expBtF);
      checkOutput(e.name, "oPCSrcD",       {31'd0, oPCSrcD}, {31'd0, e.expPcsrcD});
      checkOutput(e.name, "oTargetPC",     oTargetPC,        e.expTgtPC);
`ifdef BP_STATS_EN
      checkOutput(e.name, "oLookupCount",     oLookupCount,     e.expLookups);
      checkOutput(e.name, "oMispredictCount", oMispredictCount, e.expMispredicts);
`endif
    end
  end

  // Drive one vector right after a rising edge and queue its expectations.
  // Statistics expectations reflect events completed before this vector.
  task automatic applyStimulus(input string name,
                               input logic [31:0] pcF,
                               input logic br, input logic tk,
                               input logic [31:0] pcD, input logic [31:0] tgt,
                               input logic pt, input logic [31:0] ptg,
                               input logic st, input logic fl,
                               input logic eF, input logic [31:0] eBt,
                               input logic eD, input logic [31:0] eTgt);
    expT e;
    @(posedge iClk);
    #1;
    iPCF         = pcF;
    iBranchD     = br;
    iTakenD      = tk;
    iPCD         = pcD;
    iTargetD     = tgt;
    iPredTakenD  = pt;
    iPredTargetD = ptg;
    iStallD      = st;
    iFlushD      = fl;
    e.name           = name;
    e.expPcsrcF      = eF;
    e.expBtF         = eBt;
    e.expPcsrcD      = eD;
    e.expTgtPC       = eTgt;
    e.expLookups     = 32'(lookupTally);
    e.expMispredicts = 32'(mispredTally);
    sbQ.push_back(e);
    if (br && !st && !fl) lookupTally++;
    if (eD) mispredTally++;
  endtask

  // Fetch-only vector: no decode branch, decode PC 0 so oTargetPC is 4
  task automatic lookupOnly(input string name, input logic [31:0] pcF,
                            input logic eF, input logic [31:0] eBt);
    applyStimulus(name, pcF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0,
                  eF, eBt, 1'b0, 32'h4);
  endtask

  initial begin
    iRst         = 1'b0;
    iPCF         = 32'h0;
    iBranchD     = 1'b0;
    iTakenD      = 1'b0;
    iPCD         = 32'h0;
    iTargetD     = 32'h0;
    iPredTakenD  = 1'b0;
    iPredTargetD = 32'h0;
    iStallD      = 1'b0;
    iFlushD      = 1'b0;

    $display("[TB] starting branch_predictor_f directed vectors");

    // Outputs while reset is held
    lookupOnly("in_reset", 32'h100, 1'b0, 32'h104);
    @(negedge iClk);
    #1 iRst = 1'b1;

    lookupOnly("after_reset", 32'h100, 1'b0, 32'h104);

    // First taken branch mispredicted as not-taken; same-cycle lookup sees
    // the old (empty) entry, next cycle sees the allocation.
    applyStimulus("alloc_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104,
                  1'b0, 1'b0, 1'b0, 32'h104, 1'b1, 32'h80);
    lookupOnly("hit_100", 32'h100, 1'b1, 32'h80);

    // Two not-taken resolutions: 10 -> 01 -> 00
    applyStimulus("nt1_100", 32'h100, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104);
    applyStimulus("nt2_100", 32'h100, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0, 32'h80,
                  1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h104);
    lookupOnly("weak_100", 32'h100, 1'b0, 32'h80);

    // Four taken resolutions: 00 -> 01 -> 10 -> 11 -> 11 (saturates)
    applyStimulus("tk1_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h80);
    applyStimulus("tk2_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'h80);
    applyStimulus("tk3_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80);
    applyStimulus("tk4_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 32'h80);
    // One not-taken: 11 -> 10, still predicts taken
    applyStimulus("nt3_100", 32'h100, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h104);
    lookupOnly("still_taken_100", 32'h100, 1'b1, 32'h80);

    // Taken with a different target: wrong-target redirect and overwrite
    applyStimulus("newtgt_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h80,
                  1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h200);
    lookupOnly("hit_100_200", 32'h100, 1'b1, 32'h200);

    // Alias 0x140 shares index 0 with 0x100 but has a different tag
    lookupOnly("miss_140", 32'h140, 1'b0, 32'h144);
    applyStimulus("nt_miss_140", 32'h100, 1'b1, 1'b0, 32'h140, 32'h0, 1'b0, 32'h144,
                  1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h144);
    lookupOnly("miss_140_again", 32'h140, 1'b0, 32'h144);
    applyStimulus("alloc_140", 32'h140, 1'b1, 1'b1, 32'h140, 32'h300, 1'b0, 32'h144,
                  1'b0, 1'b0, 1'b0, 32'h144, 1'b1, 32'h300);
    lookupOnly("hit_140", 32'h140, 1'b1, 32'h300);
    lookupOnly("evicted_100", 32'h100, 1'b0, 32'h104);

    // Stalled and flushed mispredicts: no redirect, no table change
    applyStimulus("stall_140", 32'h140, 1'b1, 1'b0, 32'h140, 32'h0, 1'b1, 32'h300,
                  1'b1, 1'b0, 1'b1, 32'h300, 1'b0, 32'h144);
    applyStimulus("flush_100", 32'h100, 1'b1, 1'b1, 32'h100, 32'h400, 1'b0, 32'h104,
                  1'b0, 1'b1, 1'b0, 32'h104, 1'b0, 32'h400);
    lookupOnly("hold_140", 32'h140, 1'b1, 32'h300);
    lookupOnly("hold_100", 32'h100, 1'b0, 32'h104);

    // Fall-through PC wraps to zero
    applyStimulus("wrap_pc", 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b0, 32'h0,
                  1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    // Update in flight when reset hits: reset spans the edge, update lost
    applyStimulus("upd_before_rst", 32'h140, 1'b1, 1'b1, 32'h100, 32'h500, 1'b0, 32'h104,
                  1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h500);
    @(negedge iClk);
    #1 iRst = 1'b0;
    @(posedge iClk);
    #1;
    iBranchD = 1'b0;
    iRst     = 1'b1;
    lookupTally  = 0;
    mispredTally = 0;
    lookupOnly("cleared_100", 32'h100, 1'b0, 32'h104);
    lookupOnly("cleared_140", 32'h140, 1'b0, 32'h144);

    @(negedge iClk);
    #1;
    if (sbQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending required=0 pending", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predictor_f.md
BRANCH_PREDICTOR_F -- requirements
Module: branch_predictor_f

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning direct-mapped table depth (power of two, 4..64).
REQ-002 SHALL have parameter XLEN, default 32, meaning PC/target width.
REQ-003 SHALL have port iClk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port iRst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port iPCF  input  XLEN  fetch-stage PC being looked up.
REQ-006 SHALL have port oPCSrcF  output  1  predict taken for iPCF.
REQ-007 SHALL have port oBranchTarget  output  XLEN  predicted target for iPCF.
REQ-008 SHALL have port iBranchD  input  1  decode-stage instruction is a branch/jump.
REQ-009 SHALL have port iTakenD  input  1  resolved outcome in decode.
REQ-010 SHALL have port iPCD  input  XLEN  PC of decode instruction.
REQ-011 SHALL have port iTargetD  input  XLEN  resolved taken target.
REQ-012 SHALL have port iPredTakenD  input  1  oPCSrcF value piped with this instruction.
REQ-013 SHALL have port iPredTargetD  input  XLEN  oBranchTarget value piped with this instruction.
REQ-014 SHALL have port iStallD  input  1  decode stalled; suppresses update and redirect.
REQ-015 SHALL have port iFlushD  input  1  decode squashed; suppresses update and redirect.
REQ-016 SHALL have port oPCSrcD  output  1  mispredict; fetch must redirect.
REQ-017 SHALL have port oTargetPC  output  XLEN  corrected fetch PC.

Function
REQ-018 Each entry SHALL hold valid, tag (iPC[XLEN-1:2+log2(ENTRIES)]), target (XLEN), 2-bit saturating counter; index = PC[1+log2(ENTRIES):2].
REQ-019 Lookup SHALL be combinational, zero latency: oPCSrcF = valid && tag match && counter[1]; oBranchTarget = entry target on hit, else iPCF+4.
REQ-020 Update event U SHALL be iBranchD && !iStallD && !iFlushD.
REQ-021 oPCSrcD SHALL be U && ((iTakenD != iPredTakenD) || (iTakenD && iPredTargetD != iTargetD)); combinational, same cycle.
REQ-022 oTargetPC SHALL be iTargetD when iTakenD, else iPCD+4 (XLEN wrap-around, no carry out).
REQ-023 On U with tag hit: counter SHALL increment if taken (saturate at 2'b11), decrement if not taken (saturate at 2'b00); target SHALL be overwritten with iTargetD when taken.
REQ-024 On U with miss and iTakenD=1: entry SHALL be allocated/replaced with valid=1, new tag, iTargetD, counter=2'b10.
REQ-025 On U with miss and iTakenD=0: table SHALL NOT change.
REQ-026 Same-index lookup and update in one cycle: lookup SHALL return pre-update contents; update visible from next cycle.
REQ-027 Without U, table state SHALL hold.

Reset
REQ-028 iRst low SHALL asynchronously clear every valid bit and counter to 2'b01; tags/targets need not reset.
REQ-029 During and immediately after reset, oPCSrcF=0, oBranchTarget=iPCF+4, oPCSrcD=0 unless U asserted.
REQ-030 Reset asserted mid-update SHALL discard the update; release SHALL be synchronised to no required value other than cleared state.

Configuration
REQ-031 Macro BP_STATS_EN defined SHALL add outputs oLookupCount and oMispredictCount (32 bit, reset 0, wrap at 2^32): former increments each cycle iBranchD && !iStallD && !iFlushD, latter each cycle oPCSrcD=1.
REQ-032 Without BP_STATS_EN those ports and counters SHALL NOT exist; all other behaviour identical.

Verification
REQ-033 Reset, iPCF=0x100 -> oPCSrcF=0, oBranchTarget=0x104.
REQ-034 U: iPCD=0x100, taken, target 0x80, iPredTakenD=0 -> oPCSrcD=1, oTargetPC=0x80; next cycle iPCF=0x100 -> oPCSrcF=1, oBranchTarget=0x80.
REQ-035 Entry at 2'b10, two not-taken U at 0x100 with iPredTakenD=1 then 0 -> first oPCSrcD=1 oTargetPC=0x104, second oPCSrcD=0; lookup 0x100 -> oPCSrcF=0.
REQ-036 Four taken U then one not-taken at 0x100 -> counter 2'b11 then 2'b10, lookup still predicts taken; aliasing PC 0x140 (ENTRIES=16) misses until allocated, then replaces 0x100.
REQ-037 Mispredict U with iStallD=1 or iFlushD=1 -> oPCSrcD=0, table unchanged; iRst pulsed low after allocation -> lookup 0x100 misses.
REQ-038 With BP_STATS_EN, 3 U including 1 mispredict -> oLookupCount=3, oMispredictCount=1.
